// File: rtl/tile_pkg.sv
// Shared types and bitmap contents for the tile drawer. The bitmaps are 20x20
// RGB332 images, each source pixel shown as a 4x4 block on screen.
package tile_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WALL  = 2'd1,
    SPIKE = 2'd2,
    ANIM  = 2'd3
  } tile_t;

  localparam int         TILE_SIZE           = 80;
  localparam int         BMP_DIM             = 20;
  localparam logic [7:0] TRANSPARENT_DEFAULT = 8'hFF;

  // ROM address; its field order gives {type, phase, row, col}.
  typedef struct packed {
    tile_t      kind;
    logic       phase;
    logic [4:0] row;
    logic [4:0] col;
  } bmp_addr_t;

  typedef struct packed {
    bmp_addr_t addr;
    logic      in_range;
  } stage1_t;

  // WALL is a brick pattern, SPIKE a lower-right triangle on a clear
  // background, and ANIM a checkerboard whose second phase punches holes.
  function automatic logic [7:0] bitmap_px(input bmp_addr_t a, input logic [7:0] clear);
    logic [5:0] diag;
    logic       odd;
    diag = {1'b0, a.row} + {1'b0, a.col};
    odd  = a.row[0] ^ a.col[0];
    case (a.kind)
      WALL:    bitmap_px = (a.row[1:0] == 2'b11 || a.col[2:0] == 3'b111) ? 8'h49 : 8'hC4;
      SPIKE:   bitmap_px = (diag >= 6'd19) ? 8'hFC : clear;
      ANIM:    bitmap_px = a.phase ? (odd ? clear : 8'hE0) : (odd ? 8'h1C : 8'h03);
      default: bitmap_px = clear;
    endcase
  endfunction

endpackage

// File: rtl/tile_bitmap_rom.sv
// Bitmap lookup with a registered read; this is the second pipeline stage and
// produces the final masked colour and draw request.
module tile_bitmap_rom
  import tile_pkg::*;
#(
  parameter logic [7:0] TRANSPARENT = TRANSPARENT_DEFAULT
) (
  input  logic       clk,
  input  logic       resetN,
  input  bmp_addr_t  addr_i,
  input  logic       valid_i,
  output logic       draw_o,
  output logic [7:0] rgb_o
);

  logic [7:0] px;
  logic       draw_d, draw_q;
  logic [7:0] rgb_d, rgb_q;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    px     = bitmap_px(addr_i, TRANSPARENT);
    draw_d = valid_i && (px != TRANSPARENT);
    rgb_d  = draw_d ? px : 8'h00;
  end

  // NOTE: the bitmap is a constant table, so only the output register needs a reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      draw_q <= 1'b0;
      rgb_q  <= 8'h00;
    end else begin
      draw_q <= draw_d;
      rgb_q  <= rgb_d;
    end
  end

  assign draw_o = draw_q;
  assign rgb_o  = rgb_q;

endmodule

// File: rtl/tile_bitmap_drawer.sv
// Two-stage tile pixel drawer: stage 1 registers bitmap coordinates and phase,
// stage 2 (tile_bitmap_rom) the colour. Define TILE_ANIM_EN for animated tiles.
module tile_bitmap_drawer
  import tile_pkg::*;
#(
  parameter int unsigned ANIM_PERIOD = 16,
  parameter logic [7:0]  TRANSPARENT = TRANSPARENT_DEFAULT
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic [1:0]  Tile_type,
  input  logic        startOfFrame,
  output logic        drawingRequest,
  output logic [7:0]  RGBout
);

  logic    phase;
  stage1_t s1_d, s1_q;

`ifdef TILE_ANIM_EN
  localparam logic [7:0] PERIOD_LAST = 8'(ANIM_PERIOD - 1);

  logic [7:0] frame_cnt_q;
  logic       phase_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt_q <= 8'd0;
      phase_q     <= 1'b0;
    end else if (startOfFrame) begin
      if (frame_cnt_q == PERIOD_LAST) begin
        frame_cnt_q <= 8'd0;
        phase_q     <= ~phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign phase = phase_q;
`else
  logic unused_cfg;

  assign phase      = 1'b0;
  // Without animation the frame pulse and period have no effect.
  assign unused_cfg = startOfFrame | (ANIM_PERIOD == 0);
`endif

  always_comb begin
    s1_d.addr.kind  = tile_t'(Tile_type);
    s1_d.addr.phase = phase;
    s1_d.addr.row   = offsetY[6:2];
    s1_d.addr.col   = offsetX[6:2];
    s1_d.in_range   = (offsetX < 11'(TILE_SIZE)) && (offsetY < 11'(TILE_SIZE));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  tile_bitmap_rom #(
    .TRANSPARENT(TRANSPARENT)
  ) u_rom (
    .clk    (clk),
    .resetN (resetN),
    .addr_i (s1_q.addr),
    .valid_i(s1_q.in_range && (s1_q.addr.kind != EMPTY)),
    .draw_o (drawingRequest),
    .rgb_o  (RGBout)
  );

endmodule

// File: tb/tb_tile_bitmap_drawer.sv
// Directed bench for tile_bitmap_drawer; expectations adapt to TILE_ANIM_EN.
module tb_tile_bitmap_drawer;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic [1:0]  Tile_type;
  logic        startOfFrame;
  logic        drawingRequest;
  logic [7:0]  RGBout;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {drawingRequest, RGBout} for ANIM pixel (0,0) when phase is 1.
`ifdef TILE_ANIM_EN
  localparam logic [8:0] ANIM_PH1 = 9'h1E0;
`else
  localparam logic [8:0] ANIM_PH1 = 9'h103;
`endif

  always #5 clk = ~clk;

  tile_bitmap_drawer #(
    .ANIM_PERIOD(2),
    .TRANSPARENT(8'hFF)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .offsetX       (offsetX),
    .offsetY       (offsetY),
    .Tile_type     (Tile_type),
    .startOfFrame  (startOfFrame),
    .drawingRequest(drawingRequest),
    .RGBout        (RGBout)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pix(input logic [1:0] t, input int x, input int y);
    Tile_type = t;
    offsetX   = 11'(x);
    offsetY   = 11'(y);
  endtask

  task automatic pulse(input int n);
    startOfFrame = 1'b1;
    tick(n);
    startOfFrame = 1'b0;
  endtask

  task automatic check(input string tag, input logic [8:0] expected);
    logic [8:0] observed;
    observed = {drawingRequest, RGBout};
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed {dr,rgb}=%h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    resetN       = 1'b1;
    startOfFrame = 1'b0;
    pix(2'd0, 0, 0);

    #2 resetN = 1'b0;
    #1 check("reset_async", 9'h000);
    pix(2'd1, 0, 0);
    tick(2);
    check("reset_hold", 9'h000);

    resetN = 1'b1;
    tick(1);
    check("latency_1clk", 9'h000);
    tick(1);
    check("wall_00", 9'h1C4);

    pix(2'd0, 0, 0);     tick(2); check("empty_00", 9'h000);
    pix(2'd0, 40, 40);   tick(2); check("empty_mid", 9'h000);
    pix(2'd2, 85, 0);    tick(2); check("spike_x85", 9'h000);
    pix(2'd2, 79, 79);   tick(2); check("spike_1919", 9'h1FC);
    pix(2'd2, 0, 0);     tick(2); check("spike_transp", 9'h000);
    pix(2'd1, 79, 79);   tick(2); check("wall_1919", 9'h149);
    pix(2'd1, 80, 0);    tick(2); check("wall_x80", 9'h000);
    pix(2'd1, 0, 80);    tick(2); check("wall_y80", 9'h000);
    pix(2'd1, 0, 12);    tick(2); check("wall_row3", 9'h149);

    // One pixel per clock through the pipeline.
    pix(2'd1, 28, 0); tick(1);
    pix(2'd1, 0, 0);  tick(1); check("stream_a", 9'h149);
    pix(2'd3, 4, 0);  tick(1); check("stream_b", 9'h1C4);
    pix(2'd0, 0, 0);  tick(1); check("stream_c", 9'h11C);

    // Animation, ANIM_PERIOD = 2: phase toggles on every second pulse.
    pix(2'd3, 0, 0); tick(2); check("anim_start", 9'h103);
    pulse(1); tick(2); check("anim_pulse1", 9'h103);
    pulse(1); tick(2); check("anim_pulse2", ANIM_PH1);
    pulse(2); tick(2); check("anim_pulse4", 9'h103);
    pulse(2); tick(2); check("anim_pulse6", ANIM_PH1);
    pulse(1); tick(2); check("anim_pulse7", ANIM_PH1);
    pulse(3); tick(2); check("anim_pulse10", ANIM_PH1);

    // Reset mid-stream: in-flight pixels and phase are discarded.
    pix(2'd1, 0, 0);
    tick(1);
    resetN = 1'b0;
    #1 check("reset_midstream", 9'h000);
    pix(2'd3, 0, 0);
    tick(1);
    resetN = 1'b1;
    tick(1);
    check("post_reset_1clk", 9'h000);
    tick(1);
    check("post_reset_phase0", 9'h103);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tile_bitmap_drawer.md
TILE_BITMAP_DRAWER -- requirements
Module: tile_bitmap_drawer

Interface
REQ-001 Parameter ANIM_PERIOD, default 16, SHALL be the number of frames per animation phase (legal 1..255).
REQ-002 Parameter TRANSPARENT, default 8'hFF, SHALL be the RGB332 colour treated as "no draw".
REQ-003 clk  input  1  SHALL be the single system clock; all state on its rising edge.
REQ-004 resetN  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 offsetX  input  11  SHALL be the pixel offset inside the current 80x80 tile, from the tile-offset stage.
REQ-006 offsetY  input  11  SHALL be the vertical tile offset, same timing as offsetX.
REQ-007 Tile_type  input  2  SHALL be the tile class of the current pixel, same timing as offsetX.
REQ-008 startOfFrame  input  1  SHALL be a one-cycle pulse at the start of each VGA frame.
REQ-009 drawingRequest  output  1  SHALL be high when the pixel is an opaque tile pixel.
REQ-010 RGBout  output  8  SHALL be the RGB332 colour of the pixel, valid when drawingRequest is high.

Function
REQ-011 Bitmap index SHALL be col = offsetX[6:2] and row = offsetY[6:2], each 0..19 (20x20 bitmap, 4x4 pixel upscale).
REQ-012 Stage 1 SHALL register col, row, Tile_type, animation phase and an in-range flag (offsetX<80 and offsetY<80).
REQ-013 Stage 2 SHALL register the bitmap colour read at {type, phase, row, col} into RGBout.
REQ-014 Latency from offsetX/offsetY/Tile_type to RGBout/drawingRequest SHALL be exactly 2 clocks, fully pipelined, one pixel per clock.
REQ-015 drawingRequest SHALL be 0 when the type is EMPTY (0), the in-range flag is 0, or the read colour equals TRANSPARENT; otherwise 1.
REQ-016 RGBout SHALL be 8'h00 whenever drawingRequest is 0.
REQ-017 Types WALL (1) and SPIKE (2) SHALL each use one fixed bitmap; type ANIM (3) SHALL use bitmap 0 or 1 selected by phase.
REQ-018 An 8-bit frame counter SHALL increment on each startOfFrame pulse.
REQ-019 When startOfFrame arrives with counter = ANIM_PERIOD-1, the counter SHALL wrap to 0 and phase SHALL toggle in the same clock.
REQ-020 Phase SHALL be sampled into stage 1 per pixel, so a toggle affects only pixels entering after it.
REQ-021 startOfFrame pulses on consecutive clocks SHALL each count.

Reset
REQ-022 Asserting resetN low SHALL immediately clear drawingRequest, RGBout, all pipeline registers, the frame counter and phase to 0.
REQ-023 Reset asserted mid-frame SHALL discard in-flight pixels; the first valid output after release SHALL appear 2 clocks after the first input sample.

Configuration
REQ-024 With macro TILE_ANIM_EN defined, the frame counter and phase logic SHALL be built as in REQ-018..REQ-020.
REQ-025 Without TILE_ANIM_EN, phase SHALL be constant 0, no counter SHALL exist, startOfFrame SHALL be ignored, and ANIM tiles SHALL always show bitmap 0.

Structure
REQ-026 Package tile_pkg SHALL hold enum tile_t {EMPTY, WALL, SPIKE, ANIM}, TILE_SIZE=80, BMP_DIM=20 and the default TRANSPARENT value.
REQ-027 Bitmap storage SHALL be sub-module tile_bitmap_rom with registered read, addressed by {type, phase, row, col}; it implements stage 2.

Verification
REQ-028 Tile_type=1, offsetX=0, offsetY=0 at cycle N -> at N+2, RGBout = WALL bitmap[0][0] and drawingRequest=1 if that colour != 8'hFF.
REQ-029 Tile_type=0, any offsets -> 2 clocks later drawingRequest=0 and RGBout=8'h00.
REQ-030 Tile_type=2, offsetX=85 -> drawingRequest=0; offsetX=79, offsetY=79 -> reads bitmap[19][19].
REQ-031 TILE_ANIM_EN, ANIM_PERIOD=2, Tile_type=3 held: 2 startOfFrame pulses -> phase 1 and bitmap 1 shown; 2 more -> bitmap 0.
REQ-032 Without TILE_ANIM_EN, 10 startOfFrame pulses with Tile_type=3 -> output always from bitmap 0.
REQ-033 resetN low for 1 clock while a pixel stream is flowing -> outputs 0 at once; after release, outputs resume 2 clocks after input, with counter and phase at 0.
